// File: rtl/layer2_argmax_pkg.sv
// rtl/layer2_argmax_pkg.sv - shared sizes and FSM state encoding for the layer-2 argmax readout
package layer2_argmax_pkg;

    localparam int LAYER_2_NUM_CLASSES     = 10;
    localparam int LAYER_2_CLASS_IDX_WIDTH = 4;
    localparam int LAYER_2_OUT_BIT_WIDTH   = 16;

    typedef enum logic [1:0] {
        ARGMAX_IDLE = 2'd0,
        ARGMAX_SCAN = 2'd1,
        ARGMAX_HOLD = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - combinational signed greater-than / equal comparator
module argmax_cmp #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    assign gt = $signed(a) > $signed(b);
    assign eq = (a == b);

endmodule

// File: rtl/layer2_argmax.sv
// rtl/layer2_argmax.sv - serial signed argmax over captured layer-2 sums; ARGMAX_TIE_FLAG_EN adds tie_out
module layer2_argmax
    import layer2_argmax_pkg::*;
#(
    parameter int NUM_CLASSES = LAYER_2_NUM_CLASSES,
    parameter int SUM_W       = LAYER_2_OUT_BIT_WIDTH,
    parameter int IDX_W       = LAYER_2_CLASS_IDX_WIDTH
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [NUM_CLASSES*SUM_W-1:0] sums_in,
    input  logic                         sums_valid,
    output logic                         sums_ready,
    output logic [IDX_W-1:0]             class_out,
    output logic [SUM_W-1:0]             max_out,
    output logic                         class_valid,
    input  logic                         class_ready,
    output logic                         busy
`ifdef ARGMAX_TIE_FLAG_EN
    ,
    output logic                         tie_out
`endif
);

    argmax_state_e state, next_state;

    logic [SUM_W-1:0] shadow [NUM_CLASSES];
    logic [SUM_W-1:0] best;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] entry;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             accept;
    logic             last_cmp;

    assign entry    = shadow[idx];
    assign accept   = (state == ARGMAX_IDLE) && sums_valid;
    assign last_cmp = (state == ARGMAX_SCAN) && (idx == IDX_W'(NUM_CLASSES - 1));

    argmax_cmp #(.W(SUM_W)) u_cmp (
        .a  (entry),
        .b  (best),
        .gt (cmp_gt),
        .eq (cmp_eq)
    );

    always_ff @(posedge clk) begin
        if (!clr) state <= ARGMAX_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARGMAX_IDLE: if (sums_valid)  next_state = ARGMAX_SCAN;
            ARGMAX_SCAN: if (last_cmp)    next_state = ARGMAX_HOLD;
            ARGMAX_HOLD: if (class_ready) next_state = ARGMAX_IDLE;
            default:                      next_state = ARGMAX_IDLE;
        endcase
    end

    always_comb begin
        sums_ready  = (state == ARGMAX_IDLE) && clr;
        class_valid = (state == ARGMAX_HOLD);
        busy        = (state != ARGMAX_IDLE);
    end

    // Strict compare keeps the lowest index on ties; result latched on the final compare.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int m = 0; m < NUM_CLASSES; m++) shadow[m] <= '0;
            best      <= '0;
            best_idx  <= '0;
            idx       <= '0;
            class_out <= '0;
            max_out   <= '0;
        end else if (accept) begin
            for (int m = 0; m < NUM_CLASSES; m++) shadow[m] <= sums_in[m*SUM_W +: SUM_W];
            best     <= sums_in[SUM_W-1:0];
            best_idx <= '0;
            idx      <= IDX_W'(1);
        end else if (state == ARGMAX_SCAN) begin
            if (cmp_gt) begin
                best     <= entry;
                best_idx <= idx;
            end
            idx <= idx + IDX_W'(1);
            if (last_cmp) begin
                class_out <= cmp_gt ? idx : best_idx;
                max_out   <= cmp_gt ? entry : best;
            end
        end
    end

`ifdef ARGMAX_TIE_FLAG_EN
    logic tie_acc;

    always_ff @(posedge clk) begin
        if (!clr) begin
            tie_acc <= 1'b0;
            tie_out <= 1'b0;
        end else if (accept) begin
            tie_acc <= 1'b0;
        end else if (state == ARGMAX_SCAN) begin
            if (cmp_gt)      tie_acc <= 1'b0;
            else if (cmp_eq) tie_acc <= 1'b1;
            if (last_cmp) tie_out <= cmp_gt ? 1'b0 : (cmp_eq ? 1'b1 : tie_acc);
        end
    end
`else
    logic unused_eq;
    assign unused_eq = cmp_eq;
`endif

endmodule
